// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch path and the load/store path.
// Data side wins by default; a starvation counter forces fetch progress.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);
  localparam logic [3:0] SLIM = 4'(STARVE_LIM);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        if_win, dm_win, free, last_busy;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

  // The rvalid cycle is already IDLE, so it doubles as the next free cycle.
  assign free      = (state_q == IDLE);
  assign last_busy = (state_q == BUSY) && (cnt_q == LAT);

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (rst_n && free) begin
      if (if_req && dm_req && (starve_q == SLIM)) begin
        if_win = 1'b1;
      end else if (dm_req) begin
        dm_win = 1'b1;
      end else if (if_req) begin
        if_win = 1'b1;
      end
    end
  end

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_addr = {if_addr[31:2], 2'b00};
      mem_be   = 4'hF;
    end else if (dm_win) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = {dm_addr[31:2], 2'b00};
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rvalid_d = 1'b0;
    starve_d = starve_q;
    if (rvalid_q) owner_d = OWN_NONE;
    case (state_q)
      IDLE: begin
        if (if_win || (dm_win && !dm_we)) begin
          state_d = BUSY;
          cnt_d   = 3'd1;
          owner_d = if_win ? OWN_IF : OWN_DM;
        end
      end
      BUSY: begin
        if (cnt_q == LAT) begin
          state_d  = IDLE;
          cnt_d    = 3'd0;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (if_win) begin
      starve_d = 4'd0;
    end else if (dm_win && if_req && (starve_q != SLIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      cnt_q    <= 3'd0;
      starve_q <= 4'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Read data lands in the owner's register so the other side's word holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else if (last_busy) begin
      if (owner_q == OWN_IF) if_rdata_q <= mem_rdata;
      if (owner_q == OWN_DM) dm_rdata_q <= mem_rdata;
    end
  end

  assign if_rvalid = rvalid_q && (owner_q == OWN_IF);
  assign dm_rvalid = rvalid_q && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus
// hand sequences for reset during a read and MEM_LAT=1 back-to-back fetches.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        f_if_req;
  logic [31:0] f_if_addr, f_mem_rdata;
  logic        f_zero_b;
  logic [31:0] f_zero_w;
  logic [3:0]  f_zero_be;
  logic        f_if_gnt, f_if_rvalid, f_dm_gnt, f_dm_rvalid, f_mem_en, f_mem_we;
  logic [31:0] f_if_rdata, f_dm_rdata, f_mem_addr, f_mem_wdata;
  logic [3:0]  f_mem_be;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIM(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIM(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(f_if_req), .if_addr(f_if_addr), .if_gnt(f_if_gnt),
    .if_rvalid(f_if_rvalid), .if_rdata(f_if_rdata),
    .dm_req(f_zero_b), .dm_we(f_zero_b), .dm_addr(f_zero_w), .dm_wdata(f_zero_w),
    .dm_be(f_zero_be), .dm_gnt(f_dm_gnt), .dm_rvalid(f_dm_rvalid), .dm_rdata(f_dm_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_be(f_mem_be), .mem_rdata(f_mem_rdata)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic        dwe;
    logic [31:0] dma;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic [31:0] mrd;
    logic [5:0]  flags;   // {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}
    logic [3:0]  be;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic add(input logic [31:0] ifr, input logic [31:0] ifa,
                     input logic [31:0] dmr, input logic [31:0] dwe,
                     input logic [31:0] dma, input logic [31:0] dwd,
                     input logic [31:0] dbe, input logic [31:0] mrd,
                     input logic [5:0] flags, input logic [31:0] be,
                     input logic [31:0] ma, input logic [31:0] wd,
                     input logic [31:0] ird, input logic [31:0] drd);
    vec_t r;
    r.ifr = ifr[0]; r.ifa = ifa; r.dmr = dmr[0]; r.dwe = dwe[0];
    r.dma = dma; r.dwd = dwd; r.dbe = dbe[3:0]; r.mrd = mrd;
    r.flags = flags; r.be = be[3:0]; r.ma = ma; r.wd = wd; r.ird = ird; r.drd = drd;
    vq.push_back(r);
  endtask

  function automatic logic [5:0] act_flags();
    return {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we};
  endfunction

  task automatic check(input string name, input logic ok, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_rdata = 0;
  endtask

  localparam logic [31:0] I0 = 32'h00500093, I1 = 32'h11111111, I2 = 32'h22222222;
  localparam logic [31:0] I3 = 32'h33333333, B4 = 32'hB0000004, D7 = 32'hD0000007;
  localparam logic [31:0] DB = 32'hDEADBEEF, A1 = 32'hA0000001, A2 = 32'hA0000002;
  localparam logic [31:0] A3 = 32'hA0000003, C5 = 32'hC0000005, C6 = 32'hC0000006;

  initial begin
    logic ok;
    string gs, ws;

    // ifr ifa dmr dwe dma dwd dbe mrd | flags be addr wdata if_rdata dm_rdata
    add(1,'h100,0,0,0,0,0,0,         6'b100010,'hF,'h100,0,0,0);     // lone fetch
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,0,0);
    add(0,0,0,0,0,0,0,I0,            6'b000000,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,             6'b001000,0,0,0,I0,0);
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,I0,0);
    add(1,'h200,1,0,'h2003,0,'hF,0,  6'b010010,'hF,'h2000,0,I0,0);   // both ask, data wins
    add(1,'h200,0,0,0,0,0,0,         6'b000000,0,0,0,I0,0);
    add(1,'h200,0,0,0,0,0,DB,        6'b000000,0,0,0,I0,0);
    add(1,'h200,0,0,0,0,0,0,         6'b100110,'hF,'h200,0,I0,DB);
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,I0,DB);
    add(0,0,0,0,0,0,0,I1,            6'b000000,0,0,0,I0,DB);
    add(0,0,0,0,0,0,0,0,             6'b001000,0,0,0,I1,DB);
    add(0,0,1,1,'h44,'hABCD0000,'hC,0, 6'b010011,'hC,'h44,'hABCD0000,I1,DB); // store
    add(1,'h300,0,0,0,0,0,0,         6'b100010,'hF,'h300,0,I1,DB);
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,I1,DB);
    add(0,0,0,0,0,0,0,I2,            6'b000000,0,0,0,I1,DB);
    add(1,'h106,0,0,0,0,0,0,         6'b101010,'hF,'h104,0,I2,DB);   // misaligned fetch
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,I2,DB);
    add(0,0,0,0,0,0,0,I3,            6'b000000,0,0,0,I2,DB);
    add(0,0,0,0,0,0,0,0,             6'b001000,0,0,0,I3,DB);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b010010,'hF,'h1000,0,I3,DB);  // starvation run
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b000000,0,0,0,I3,DB);
    add(1,'h400,1,0,'h1000,0,'hF,A1, 6'b000000,0,0,0,I3,DB);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b010110,'hF,'h1000,0,I3,A1);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b000000,0,0,0,I3,A1);
    add(1,'h400,1,0,'h1000,0,'hF,A2, 6'b000000,0,0,0,I3,A1);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b010110,'hF,'h1000,0,I3,A2);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b000000,0,0,0,I3,A2);
    add(1,'h400,1,0,'h1000,0,'hF,A3, 6'b000000,0,0,0,I3,A2);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b100110,'hF,'h400,0,I3,A3);   // fetch wins 4th
    add(0,0,1,0,'h1000,0,'hF,0,      6'b000000,0,0,0,I3,A3);
    add(0,0,1,0,'h1000,0,'hF,B4,     6'b000000,0,0,0,I3,A3);
    add(0,0,1,0,'h1000,0,'hF,0,      6'b011010,'hF,'h1000,0,B4,A3);
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,B4,A3);
    add(0,0,0,0,0,0,0,C5,            6'b000000,0,0,0,B4,A3);
    add(0,0,0,0,0,0,0,0,             6'b000100,0,0,0,B4,C5);
    add(1,'h400,1,0,'h1000,0,'hF,0,  6'b010010,'hF,'h1000,0,B4,C5);  // counter was cleared
    add(1,'h400,0,0,0,0,0,0,         6'b000000,0,0,0,B4,C5);
    add(1,'h400,0,0,0,0,0,C6,        6'b000000,0,0,0,B4,C5);
    add(1,'h400,0,0,0,0,0,0,         6'b100110,'hF,'h400,0,B4,C6);
    add(0,0,0,0,0,0,0,0,             6'b000000,0,0,0,B4,C6);
    add(0,0,0,0,0,0,0,D7,            6'b000000,0,0,0,B4,C6);
    add(0,0,0,0,0,0,0,0,             6'b001000,0,0,0,D7,C6);

    // Reset state with both requests asserted
    rst_n = 1'b0;
    drive_idle();
    if_req = 1; dm_req = 1; if_addr = 'h10; dm_addr = 'h20; dm_be = 'hF;
    f_if_req = 0; f_if_addr = 0; f_mem_rdata = 0;
    f_zero_b = 0; f_zero_w = 0; f_zero_be = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ok = (act_flags() == 6'b0) && mem_addr == 0 && mem_be == 0 && mem_wdata == 0 &&
         if_rdata == 0 && dm_rdata == 0 && f_if_gnt == 0;
    $sformat(gs, "flags=%b addr=%h be=%h", act_flags(), mem_addr, mem_be);
    check("reset_state", ok, gs, "all zero");
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b1;

    foreach (vq[i]) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if_req = vq[i].ifr; if_addr = vq[i].ifa; dm_req = vq[i].dmr; dm_we = vq[i].dwe;
      dm_addr = vq[i].dma; dm_wdata = vq[i].dwd; dm_be = vq[i].dbe; mem_rdata = vq[i].mrd;
      @(negedge clk);
      ok = (act_flags() == vq[i].flags) && (mem_be == vq[i].be) && (mem_addr == vq[i].ma) &&
           (mem_wdata == vq[i].wd) && (if_rdata == vq[i].ird) && (dm_rdata == vq[i].drd);
      $sformat(gs, "flags=%b be=%h addr=%h wd=%h ird=%h drd=%h",
               act_flags(), mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata);
      $sformat(ws, "flags=%b be=%h addr=%h wd=%h ird=%h drd=%h",
               vq[i].flags, vq[i].be, vq[i].ma, vq[i].wd, vq[i].ird, vq[i].drd);
      check($sformatf("vec%0d", i), ok, gs, ws);
    end

    // Reset asserted in the cycle after a load issue
    @(posedge clk); #1;
    drive_idle();
    dm_req = 1; dm_addr = 'h80; dm_be = 'hF;
    @(negedge clk);
    check("rst_load_issue", dm_gnt && mem_addr == 'h80,
          $sformatf("gnt=%b addr=%h", dm_gnt, mem_addr), "gnt=1 addr=00000080");
    @(posedge clk); #1;
    drive_idle();
    if_req = 1; if_addr = 'h500; mem_rdata = 'hEEEEEEEE;
    rst_n = 1'b0;
    #1;
    ok = (act_flags() == 6'b0) && mem_addr == 0 && mem_be == 0 && if_rdata == 0 && dm_rdata == 0;
    $sformat(gs, "flags=%b addr=%h ird=%h drd=%h", act_flags(), mem_addr, if_rdata, dm_rdata);
    check("rst_midread_zero", ok, gs, "all zero");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rdata = 'hEEEEEEEE;
    @(negedge clk);
    check("rst_release_gnt", if_gnt && !dm_gnt && mem_addr == 'h500 && !dm_rvalid,
          $sformatf("ig=%b dg=%b addr=%h dv=%b", if_gnt, dm_gnt, mem_addr, dm_rvalid),
          "ig=1 dg=0 addr=00000500 dv=0");
    @(posedge clk); #1;
    if_req = 0; mem_rdata = 0;
    @(negedge clk);
    check("rst_no_rvalid1", !dm_rvalid && !if_rvalid,
          $sformatf("dv=%b iv=%b", dm_rvalid, if_rvalid), "dv=0 iv=0");
    @(posedge clk); #1;
    mem_rdata = 'h5A5A5A5A;
    @(negedge clk);
    check("rst_no_rvalid2", !dm_rvalid && !if_rvalid,
          $sformatf("dv=%b iv=%b", dm_rvalid, if_rvalid), "dv=0 iv=0");
    @(posedge clk); #1;
    mem_rdata = 0;
    @(negedge clk);
    check("rst_fetch_return", if_rvalid && !dm_rvalid && if_rdata == 'h5A5A5A5A && dm_rdata == 0,
          $sformatf("iv=%b dv=%b ird=%h drd=%h", if_rvalid, dm_rvalid, if_rdata, dm_rdata),
          "iv=1 dv=0 ird=5a5a5a5a drd=00000000");

    // MEM_LAT=1: continuous fetch, one issue every two cycles
    for (int k = 0; k < 8; k++) begin
      logic eg, ev;
      logic [31:0] ea, ed;
      @(posedge clk); #1;
      f_if_req = 1; f_if_addr = 32'h1000 + 32'(4 * k); f_mem_rdata = 32'h10000000 + 32'(k);
      eg = (k % 2 == 0);
      ev = (k >= 2) && (k % 2 == 0);
      ea = 32'h1000 + 32'(4 * k);
      ed = 32'h10000000 + 32'(k - 1);
      @(negedge clk);
      ok = (f_if_gnt == eg) && (f_if_rvalid == ev) && (!eg || f_mem_addr == ea) &&
           (!ev || f_if_rdata == ed);
      $sformat(gs, "gnt=%b rv=%b addr=%h rd=%h", f_if_gnt, f_if_rvalid, f_mem_addr, f_if_rdata);
      $sformat(ws, "gnt=%b rv=%b addr=%h rd=%h", eg, ev, ea, ed);
      check($sformatf("lat1_k%0d", k), ok, gs, ws);
    end
    @(posedge clk); #1;
    f_if_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
